// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encoding and default operand width.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_sub_struct.sv
// One-bit full subtractor cell: Y = A - B - borw_in.
// Purely combinational, gate-level form.
module full_sub_struct (
  input  logic A,
  input  logic B,
  input  logic borw_in,
  output logic Y,
  output logic borw_out
);

  logic axb;

  assign axb      = A ^ B;
  assign Y        = axb ^ borw_in;
  assign borw_out = (~A & B) | (~axb & borw_in);

endmodule

// File: rtl/serial_sub_unit.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Start/busy/done handshake; result held until next completion.
module serial_sub_unit
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic cell_y;
  logic cell_bo;
  logic load;
  logic last;

  full_sub_struct u_cell (
    .A        (a_sh[0]),
    .B        (b_sh[0]),
    .borw_in  (brw),
    .Y        (cell_y),
    .borw_out (cell_bo)
  );

  assign load = (state_q == ST_IDLE) && start;
  assign last = (state_q == ST_SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shift datapath: operands drain LSB first, result fills from MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      d_sh <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= a;
      b_sh <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= {cell_y, d_sh[WIDTH-1:1]};
      brw  <= cell_bo;
      cnt  <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last) begin
      diff <= {cell_y, d_sh[WIDTH-1:1]};
      bout <= cell_bo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d != ST_IDLE);
      done <= (state_d == ST_DONE);
    end
  end

endmodule
